seq_bit_serializer: RTL

//  Parallel-to-serial stage that feeds the serial sequence detectors (e.g. the "1111" Moore detector).

---
 rtl/seq_bit_serializer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in over valid/ready, shifted out MSB-first with GAP idle cycles between frames.
// Optional build macro SER_PARITY_EN appends an even-parity bit (^din) after din[0].
module seq_bit_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_done,
    output logic             busy
);

`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [FRAME-2:0] shreg_reg, shreg_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             out_reg, out_next;
    logic             ov_reg, ov_next;
    logic             fd_reg, fd_next;
    logic             busy_reg, busy_next;
    logic [FRAME-1:0] frame_word;
    logic             last_bit;
    logic             gap_last;
    logic             handshake;

`ifdef SER_PARITY_EN
    assign frame_word = {din, ^din};
`else
    assign frame_word = din;
`endif

    // cnt_reg is the index of the bit currently on out
    assign last_bit  = (state_reg == S_SHIFT) && (cnt_reg == CW'(FRAME - 1));
    assign din_ready = !rst && ((state_reg == S_IDLE) || (last_bit && (GAP == 0)) || gap_last);
    assign handshake = din_valid && din_ready;

    generate
        if (GAP > 0) begin : g_gap
            localparam int GW = $clog2(GAP + 1);
            logic [GW-1:0] gcnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    gcnt_reg <= '0;
                end else if ((state_reg == S_GAP) && !gap_last) begin
                    gcnt_reg <= gcnt_reg + 1'b1;
                end else begin
                    gcnt_reg <= '0;
                end
            end

            assign gap_last = (state_reg == S_GAP) && (gcnt_reg == GW'(GAP - 1));
        end else begin : g_nogap
            assign gap_last = 1'b0;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        out_next   = 1'b0;
        ov_next    = 1'b0;
        fd_next    = 1'b0;
        busy_next  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                state_next = S_IDLE;
            end
            S_SHIFT: begin
                if (!last_bit) begin
                    out_next   = shreg_reg[FRAME-2];
                    shreg_next = shreg_reg << 1;
                    cnt_next   = cnt_reg + 1'b1;
                    ov_next    = 1'b1;
                    busy_next  = 1'b1;
                    fd_next    = (cnt_reg == CW'(FRAME - 2));
                end else begin
                    cnt_next   = '0;
                    shreg_next = '0;
                    if (GAP > 0) begin
                        state_next = S_GAP;
                        busy_next  = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                busy_next = 1'b1;
                if (gap_last) begin
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
                shreg_next = '0;
                cnt_next   = '0;
            end
        endcase

        // A handshake is only possible where a new frame may start, so it overrides the above
        if (handshake) begin
            state_next = S_SHIFT;
            out_next   = frame_word[FRAME-1];
            shreg_next = frame_word[FRAME-2:0];
            cnt_next   = '0;
            ov_next    = 1'b1;
            busy_next  = 1'b1;
            fd_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            out_reg   <= 1'b0;
            ov_reg    <= 1'b0;
            fd_reg    <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
            out_reg   <= out_next;
            ov_reg    <= ov_next;
            fd_reg    <= fd_next;
            busy_reg  <= busy_next;
        end
    end

    assign out        = out_reg;
    assign out_valid  = ov_reg;
    assign frame_done = fd_reg;
    assign busy       = busy_reg;

endmodule
